// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types for the memory bus arbiter: basic word types, the latched
//   request record, FSM state encoding and requester identifiers.
//   No ports (package).
package mem_arbiter_pkg;

    typedef logic [31:0] u32;
    typedef logic [3:0]  u4;

    // Request fields captured at grant time and replayed onto the bus.
    typedef struct packed {
        logic write;
        u32   addr;
        u32   wdata;
        u4    strobe;
    } mem_req_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ_I,
        REQ_D,
        WAIT_I,
        WAIT_D
    } arb_state_t;

    typedef enum logic {
        SRC_I,
        SRC_D
    } arb_src_t;

    // Instruction fetches are always full-word reads.
    localparam u4 STROBE_ALL = 4'hF;

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// arb_watchdog
//   Saturating wait counter for the bus response phase.
//   Ports:
//     clk, resetn : clock and asynchronous active-low reset
//     clear       : restart the count (asserted on bus accept)
//     enable      : count this cycle (asserted while waiting for bus_ok)
//     expired     : this waiting cycle is the MAX_WAIT-th since accept
//   MAX_WAIT = 0 disables expiry; the counter then just saturates.
module arb_watchdog #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // The accept cycle clears the counter, so the count lags the number of
    // cycles since accept by one; expire when the count is MAX_WAIT-1.
    localparam int              LAST_I = (MAX_WAIT == 0) ? 0 : MAX_WAIT - 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LAST_I);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != '1)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (MAX_WAIT != 0) && enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory bus between instruction fetch (I) and data access (D).
//   One outstanding transaction; D wins over I unless MEM_ARBITER_RR_EN is
//   defined, in which case simultaneous requests alternate (last_grant).
//   Ports:
//     clk, resetn                       : clock, async active-low reset
//     ireq_valid/addr                   : fetch request (held until iresp_ok)
//     iresp_ok/data                     : fetch completion, data 0 when idle
//     dreq_valid/write/addr/wdata/strobe: data request (held until dresp_ok)
//     dresp_ok/data                     : data completion, data 0 when idle
//     bus_valid/write/addr/wdata/strobe : registered bus request
//     bus_ready, bus_ok, bus_rdata      : bus accept, response, read data
//     bus_timeout                       : pulse when the watchdog ends a wait
//   Handshake: the bus accepts when bus_valid && bus_ready; the response is
//   the first bus_ok at or after the accept cycle. Responses to requesters
//   are single-cycle x_resp_ok pulses, combinational from bus_ok.
//   Optional macro: MEM_ARBITER_RR_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ireq_valid,
    input  logic [31:0] ireq_addr,
    output logic        iresp_ok,
    output logic [31:0] iresp_data,
    input  logic        dreq_valid,
    input  logic        dreq_write,
    input  logic [31:0] dreq_addr,
    input  logic [31:0] dreq_wdata,
    input  logic [3:0]  dreq_strobe,
    output logic        dresp_ok,
    output logic [31:0] dresp_data,
    output logic        bus_valid,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_strobe,
    input  logic        bus_ready,
    input  logic        bus_ok,
    input  logic [31:0] bus_rdata,
    output logic        bus_timeout
);

    arb_state_t state_q, state_d;
    mem_req_t   req_q, req_d;
    logic       bus_valid_q, bus_valid_d;
    arb_src_t   grant;
    logic       resp_fire;
    u32         resp_data;
    logic       resp_is_d;
    logic       wd_clear, wd_enable, wd_expired;
`ifdef MEM_ARBITER_RR_EN
    arb_src_t   last_grant_q, last_grant_d;
`endif

    arb_watchdog #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Grant selection, only consulted in IDLE.
    always_comb begin
`ifdef MEM_ARBITER_RR_EN
        if (dreq_valid && ireq_valid) begin
            grant = (last_grant_q == SRC_I) ? SRC_D : SRC_I;
        end else begin
            grant = dreq_valid ? SRC_D : SRC_I;
        end
`else
        grant = dreq_valid ? SRC_D : SRC_I;
`endif
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        bus_valid_d = 1'b0;
        resp_fire   = 1'b0;
        resp_data   = '0;
        bus_timeout = 1'b0;
        wd_clear    = 1'b0;
        wd_enable   = 1'b0;
`ifdef MEM_ARBITER_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (dreq_valid || ireq_valid) begin
                    bus_valid_d = 1'b1;
                    if (grant == SRC_D) begin
                        req_d.write  = dreq_write;
                        req_d.addr   = dreq_addr;
                        req_d.wdata  = dreq_wdata;
                        req_d.strobe = dreq_strobe;
                        state_d      = REQ_D;
                    end else begin
                        req_d.write  = 1'b0;
                        req_d.addr   = ireq_addr;
                        req_d.wdata  = '0;
                        req_d.strobe = STROBE_ALL;
                        state_d      = REQ_I;
                    end
`ifdef MEM_ARBITER_RR_EN
                    last_grant_d = grant;
`endif
                end
            end
            REQ_I, REQ_D: begin
                bus_valid_d = 1'b1;
                // bus_ok before the accept belongs to nobody and is ignored.
                if (bus_ready) begin
                    bus_valid_d = 1'b0;
                    if (bus_ok) begin
                        resp_fire = 1'b1;
                        resp_data = bus_rdata;
                        state_d   = IDLE;
                    end else begin
                        wd_clear = 1'b1;
                        state_d  = (state_q == REQ_D) ? WAIT_D : WAIT_I;
                    end
                end
            end
            WAIT_I, WAIT_D: begin
                wd_enable = 1'b1;
                if (bus_ok) begin
                    resp_fire = 1'b1;
                    resp_data = bus_rdata;
                    state_d   = IDLE;
                end else if (wd_expired) begin
                    resp_fire   = 1'b1;
                    bus_timeout = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            req_q        <= '0;
            bus_valid_q  <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
            last_grant_q <= SRC_I;
`endif
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            bus_valid_q  <= bus_valid_d;
`ifdef MEM_ARBITER_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Response routing: the side is implied by the current state.
    assign resp_is_d  = (state_q == REQ_D) || (state_q == WAIT_D);
    assign iresp_ok   = resp_fire && !resp_is_d;
    assign dresp_ok   = resp_fire && resp_is_d;
    assign iresp_data = iresp_ok ? resp_data : '0;
    assign dresp_data = dresp_ok ? resp_data : '0;

    assign bus_valid  = bus_valid_q;
    assign bus_write  = req_q.write;
    assign bus_addr   = req_q.addr;
    assign bus_wdata  = req_q.wdata;
    assign bus_strobe = req_q.strobe;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter. Two instances share all inputs: u_dut
//   with MAX_WAIT=4 (watchdog active) and u_dut0 with MAX_WAIT=0 (waits
//   forever). Inputs change 1 time unit after the rising edge; outputs are
//   sampled on the falling edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        dreq_valid;
    logic        dreq_write;
    logic [31:0] dreq_addr;
    logic [31:0] dreq_wdata;
    logic [3:0]  dreq_strobe;
    logic        bus_ready;
    logic        bus_ok;
    logic [31:0] bus_rdata;

    logic        iresp_ok, dresp_ok, bus_valid, bus_write, bus_timeout;
    logic [31:0] iresp_data, dresp_data, bus_addr, bus_wdata;
    logic [3:0]  bus_strobe;

    logic        z_iresp_ok, z_dresp_ok, z_bus_valid, z_bus_write, z_bus_timeout;
    logic [31:0] z_iresp_data, z_dresp_data, z_bus_addr, z_bus_wdata;
    logic [3:0]  z_bus_strobe;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_WAIT(4), .CNT_W(8)) u_dut (
        .clk(clk), .resetn(resetn),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_ok(iresp_ok), .iresp_data(iresp_data),
        .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
        .dreq_wdata(dreq_wdata), .dreq_strobe(dreq_strobe),
        .dresp_ok(dresp_ok), .dresp_data(dresp_data),
        .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_strobe(bus_strobe),
        .bus_ready(bus_ready), .bus_ok(bus_ok), .bus_rdata(bus_rdata),
        .bus_timeout(bus_timeout)
    );

    mem_arbiter #(.MAX_WAIT(0), .CNT_W(8)) u_dut0 (
        .clk(clk), .resetn(resetn),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_ok(z_iresp_ok), .iresp_data(z_iresp_data),
        .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
        .dreq_wdata(dreq_wdata), .dreq_strobe(dreq_strobe),
        .dresp_ok(z_dresp_ok), .dresp_data(z_dresp_data),
        .bus_valid(z_bus_valid), .bus_write(z_bus_write), .bus_addr(z_bus_addr),
        .bus_wdata(z_bus_wdata), .bus_strobe(z_bus_strobe),
        .bus_ready(bus_ready), .bus_ok(bus_ok), .bus_rdata(bus_rdata),
        .bus_timeout(z_bus_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        resetn      = 1'b0;
        ireq_valid  = 1'b0;
        ireq_addr   = '0;
        dreq_valid  = 1'b0;
        dreq_write  = 1'b0;
        dreq_addr   = '0;
        dreq_wdata  = '0;
        dreq_strobe = '0;
        bus_ready   = 1'b0;
        bus_ok      = 1'b0;
        bus_rdata   = '0;

        // Reset state
        repeat (2) step();
        sample();
        chk("rst_bus_valid", bus_valid, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_strobe", bus_strobe, 0);
        chk("rst_iresp_ok", iresp_ok, 0);
        chk("rst_dresp_ok", dresp_ok, 0);
        chk("rst_timeout", bus_timeout, 0);
        step();
        resetn = 1'b1;

        // Single I read: accept at c1, bus_ok at c3
        ireq_valid = 1'b1; ireq_addr = 32'h0000_0040;
        sample(); chk("t1_c0_bus_valid", bus_valid, 0);
        step(); bus_ready = 1'b1;
        sample();
        chk("t1_c1_bus_valid", bus_valid, 1);
        chk("t1_c1_bus_addr", bus_addr, 32'h40);
        chk("t1_c1_bus_write", bus_write, 0);
        chk("t1_c1_bus_strobe", bus_strobe, 4'hF);
        chk("t1_c1_iresp_ok", iresp_ok, 0);
        step(); bus_ready = 1'b0;
        sample();
        chk("t1_c2_bus_valid", bus_valid, 0);
        chk("t1_c2_iresp_ok", iresp_ok, 0);
        step(); bus_ok = 1'b1; bus_rdata = 32'h2408_0005;
        sample();
        chk("t1_c3_iresp_ok", iresp_ok, 1);
        chk("t1_c3_iresp_data", iresp_data, 32'h2408_0005);
        step(); bus_ok = 1'b0; bus_rdata = '0; ireq_valid = 1'b0;
        sample();
        chk("t1_c4_iresp_ok", iresp_ok, 0);
        chk("t1_c4_iresp_data", iresp_data, 0);
        step();

        // Simultaneous requests: D store first (same-cycle accept/response),
        // then I after one IDLE cycle
        ireq_valid = 1'b1; ireq_addr = 32'h0000_0100;
        dreq_valid = 1'b1; dreq_write = 1'b1; dreq_addr = 32'h0000_2000;
        dreq_wdata = 32'hDEAD_BEEF; dreq_strobe = 4'h3;
        sample(); chk("t2_c0_bus_valid", bus_valid, 0);
        step(); bus_ready = 1'b1; bus_ok = 1'b1; bus_rdata = 32'h1234_5678;
        sample();
        chk("t2_d_bus_valid", bus_valid, 1);
        chk("t2_d_bus_write", bus_write, 1);
        chk("t2_d_bus_strobe", bus_strobe, 4'h3);
        chk("t2_d_bus_addr", bus_addr, 32'h2000);
        chk("t2_d_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
        chk("t2_d_dresp_ok", dresp_ok, 1);
        chk("t2_d_dresp_data", dresp_data, 32'h1234_5678);
        chk("t2_d_iresp_ok", iresp_ok, 0);
        step(); dreq_valid = 1'b0; bus_ready = 1'b0; bus_ok = 1'b0; bus_rdata = '0;
        sample();
        chk("t2_idle_bus_valid", bus_valid, 0);
        chk("t2_idle_dresp_ok", dresp_ok, 0);
        chk("t2_idle_dresp_data", dresp_data, 0);
        step(); bus_ready = 1'b1;
        sample();
        chk("t2_i_bus_valid", bus_valid, 1);
        chk("t2_i_bus_addr", bus_addr, 32'h100);
        chk("t2_i_bus_write", bus_write, 0);
        chk("t2_i_bus_strobe", bus_strobe, 4'hF);
        chk("t2_i_bus_wdata", bus_wdata, 0);
        step(); bus_ready = 1'b0; bus_ok = 1'b1; bus_rdata = 32'hCAFE_0001;
        sample();
        chk("t2_i_iresp_ok", iresp_ok, 1);
        chk("t2_i_iresp_data", iresp_data, 32'hCAFE_0001);
        chk("t2_i_dresp_ok", dresp_ok, 0);
        step(); ireq_valid = 1'b0; bus_ok = 1'b0; bus_rdata = '0;

        // Watchdog: accept at c1, no bus_ok; timeout at c5 on MAX_WAIT=4,
        // MAX_WAIT=0 instance keeps waiting and takes the late bus_ok
        ireq_valid = 1'b1; ireq_addr = 32'h0000_0080;
        step(); bus_ready = 1'b1;
        for (int c = 2; c <= 4; c++) begin
            step(); bus_ready = 1'b0;
            sample();
            chk($sformatf("t3_c%0d_iresp_ok", c), iresp_ok, 0);
            chk($sformatf("t3_c%0d_timeout", c), bus_timeout, 0);
        end
        step();
        sample();
        chk("t3_c5_iresp_ok", iresp_ok, 1);
        chk("t3_c5_iresp_data", iresp_data, 0);
        chk("t3_c5_timeout", bus_timeout, 1);
        chk("t3_c5_mw0_iresp_ok", z_iresp_ok, 0);
        chk("t3_c5_mw0_timeout", z_bus_timeout, 0);
        step(); ireq_valid = 1'b0; bus_ok = 1'b1; bus_rdata = 32'h0000_55AA;
        sample();
        chk("t3_late_iresp_ok", iresp_ok, 0);
        chk("t3_late_iresp_data", iresp_data, 0);
        chk("t3_late_timeout", bus_timeout, 0);
        chk("t3_late_mw0_iresp_ok", z_iresp_ok, 1);
        chk("t3_late_mw0_iresp_data", z_iresp_data, 32'h0000_55AA);
        step(); bus_ok = 1'b0; bus_rdata = '0;

        // Stall: bus_ready low for 10 cycles in REQ_I
        ireq_valid = 1'b1; ireq_addr = 32'h0000_0044;
        step();
        for (int i = 0; i < 10; i++) begin
            sample();
            chk($sformatf("t4_stall%0d_bus_valid", i), bus_valid, 1);
            chk($sformatf("t4_stall%0d_bus_addr", i), bus_addr, 32'h44);
            step();
        end
        bus_ready = 1'b1;
        sample(); chk("t4_accept_bus_valid", bus_valid, 1);
        step(); bus_ready = 1'b0;
        sample(); chk("t4_a1_iresp_ok", iresp_ok, 0);
        step();
        sample(); chk("t4_a2_iresp_ok", iresp_ok, 0);
        step(); bus_ok = 1'b1; bus_rdata = 32'h4444_0044;
        sample();
        chk("t4_a3_iresp_ok", iresp_ok, 1);
        chk("t4_a3_iresp_data", iresp_data, 32'h4444_0044);
        chk("t4_a3_timeout", bus_timeout, 0);
        step(); ireq_valid = 1'b0; bus_ok = 1'b0; bus_rdata = '0;

        // Reset in WAIT_D: outputs drop at once, no dresp_ok, then the
        // pending fetch is granted normally
        dreq_valid = 1'b1; dreq_write = 1'b0; dreq_addr = 32'h0000_0300;
        dreq_wdata = '0; dreq_strobe = 4'hF;
        ireq_valid = 1'b1; ireq_addr = 32'h0000_0400;
        step(); bus_ready = 1'b1;
        sample(); chk("t5_d_bus_addr", bus_addr, 32'h300);
        step(); bus_ready = 1'b0;
        #2; bus_ok = 1'b1; bus_rdata = 32'h0000_0077; resetn = 1'b0;
        #1;
        chk("t5_rst_dresp_ok", dresp_ok, 0);
        chk("t5_rst_dresp_data", dresp_data, 0);
        chk("t5_rst_bus_valid", bus_valid, 0);
        chk("t5_rst_bus_addr", bus_addr, 0);
        chk("t5_rst_bus_strobe", bus_strobe, 0);
        dreq_valid = 1'b0;
        step(); bus_ok = 1'b0; bus_rdata = '0; resetn = 1'b1;
        sample();
        chk("t5_idle_bus_valid", bus_valid, 0);
        chk("t5_idle_dresp_ok", dresp_ok, 0);
        step(); bus_ready = 1'b1; bus_ok = 1'b1; bus_rdata = 32'h0000_0099;
        sample();
        chk("t5_i_bus_valid", bus_valid, 1);
        chk("t5_i_bus_addr", bus_addr, 32'h400);
        chk("t5_i_iresp_ok", iresp_ok, 1);
        chk("t5_i_iresp_data", iresp_data, 32'h0000_0099);
        chk("t5_i_dresp_ok", dresp_ok, 0);
        step(); ireq_valid = 1'b0; bus_ready = 1'b0; bus_ok = 1'b0; bus_rdata = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one external memory bus between instruction fetch (I side) and the MEM stage data access (D side).
- Sits between the fetch/memory pipeline stages and the memory bus.
- Allows one outstanding transaction at a time. Fixed D-over-I priority by default.
- A wait watchdog terminates bus transactions that never complete.

Parameters:
- MAX_WAIT, 255: cycles allowed from bus accept to bus_ok before forced termination. 0 disables the watchdog.
- CNT_W, 8: watchdog counter width. Must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- ireq_valid  in  1  fetch request pending.
- ireq_addr  in  32  fetch address.
- iresp_ok  out  1  fetch completion pulse.
- iresp_data  out  32  fetched word, valid with iresp_ok.
- dreq_valid  in  1  data request pending.
- dreq_write  in  1  1 = store.
- dreq_addr  in  32  data address.
- dreq_wdata  in  32  store data.
- dreq_strobe  in  4  byte enables.
- dresp_ok  out  1  data completion pulse.
- dresp_data  out  32  load word, valid with dresp_ok.
- bus_valid  out  1  bus request.
- bus_write  out  1  bus store flag.
- bus_addr  out  32  bus address.
- bus_wdata  out  32  bus store data.
- bus_strobe  out  4  bus byte enables.
- bus_ready  in  1  bus accepts request this cycle.
- bus_ok  in  1  bus response valid.
- bus_rdata  in  32  bus read data.
- bus_timeout  out  1  one-cycle pulse on watchdog termination.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, latched request cleared, watchdog=0.
  - All outputs 0.
  - An in-flight transaction is abandoned; no resp_ok is issued for it.
- Requester rules:
  - A requester holds valid and all request fields stable until its resp_ok.
  - The arbiter ignores that requester's valid in the resp_ok cycle.
- States: IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D.
- IDLE:
  - Sample valids and grant one requester; latch its fields (I side: write=0, strobe=4'hF, wdata=0).
  - Next state is REQ_x. bus_valid=0 in IDLE.
  - Grant rule: dreq_valid wins over ireq_valid.
- REQ_x:
  - bus_valid=1, bus_* driven from the latched fields (registered; stable while waiting).
  - On bus_ready=1 with bus_ok=0: go to WAIT_x, clear watchdog.
  - On bus_ready=1 with bus_ok=1 in the same cycle: complete immediately (x_resp_ok=1, x_resp_data=bus_rdata), go to IDLE.
  - bus_ok arriving before bus_ready is ignored.
- WAIT_x:
  - bus_valid=0; the watchdog increments each cycle.
  - On bus_ok=1: x_resp_ok=1 combinationally, x_resp_data=bus_rdata, go to IDLE.
  - If MAX_WAIT!=0 and the watchdog reaches MAX_WAIT with bus_ok=0: x_resp_ok=1, x_resp_data=0, bus_timeout=1, go to IDLE.
  - Any bus_ok arriving after a timeout is dropped.
- Minimum latency:
  - Request seen in IDLE at cycle 0, bus_valid at cycle 1.
  - With bus_ready and bus_ok both at cycle 1, resp_ok at cycle 1.
  - Back-to-back grants are separated by one IDLE cycle.
- Response outputs iresp_data/dresp_data are 0 whenever the matching resp_ok=0.
- Stores return dresp_ok with dresp_data=bus_rdata; the requester ignores the data.
- Watchdog saturates and never wraps.

Optional Feature:
- Macro: MEM_ARBITER_RR_EN.
- Defined:
  - A 1-bit last_grant register (reset: I) selects the grant when both valids are high in IDLE: the side not granted last wins.
  - last_grant updates on every grant.
  - Single-requester cycles grant as usual.
- Undefined: fixed D priority; no last_grant register exists.

Decomposition:
- pipes package:
  - mem_req_t struct {write, addr u32, wdata u32, strobe 4b}.
  - arb_state_t enum {IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D}.
  - arb_src_t enum {SRC_I, SRC_D}.
- common package: u32, and a u4 typedef if not already present.
- One sub-module: arb_watchdog. Inputs clk, resetn, clear, enable. Output expired. Contains the saturating counter and the MAX_WAIT compare.
- FSM and routing stay in mem_arbiter.

Test Plan:
- Single I read:
  - Stimulus: ireq_valid=1, addr 0x0000_0040; bus_ready at cycle 1, bus_ok at cycle 3 with rdata 0x2408_0005.
  - Response: bus_addr=0x40, bus_write=0, bus_strobe=F; iresp_ok single pulse at cycle 3, iresp_data=0x2408_0005.
- Simultaneous requests:
  - Stimulus: ireq 0x100 and dreq store 0x2000 (wdata 0xDEADBEEF, strobe 0x3) both raised at cycle 0.
  - Response: D granted first (bus_write=1, strobe=0x3); I issued after dresp_ok plus one IDLE cycle.
  - With MEM_ARBITER_RR_EN: a second simultaneous pair grants I first.
- Same-cycle accept/response:
  - Stimulus: bus_ready=bus_ok=1 in the REQ_D cycle, rdata 0x1234_5678.
  - Response: dresp_ok in that same cycle, data 0x1234_5678; state IDLE next cycle.
- Watchdog:
  - Stimulus: MAX_WAIT=4, bus accepts an I read, bus_ok never arrives.
  - Response: iresp_ok=1, iresp_data=0 and bus_timeout=1 exactly 4 cycles after accept; a late bus_ok is ignored.
  - With MAX_WAIT=0: the arbiter waits indefinitely.
- Reset mid-transaction:
  - Stimulus: resetn=0 asynchronously in WAIT_D.
  - Response: all outputs 0 immediately; no dresp_ok; after release a pending ireq is granted normally.
- Stall on bus_ready=0:
  - Stimulus: bus_ready held 0 for 10 cycles in REQ_I.
  - Response: bus_valid and bus_* remain stable; the watchdog does not count.
